// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32I field-set to instruction-word encoder with output FIFO
//
// Purpose: packs opcode/register/funct/immediate fields into a 32-bit RV32I
// word (I, S, B, J and R formats) and buffers the result in a small FIFO.
// Field sets carrying an unsupported opcode are dropped and flagged on err.
//
// Ports:
//   clk        - single clock, rising edge
//   reset      - synchronous, active-low reset
//   in_valid   - field set on in_* is valid
//   in_ready   - encoder can accept a field set (FIFO not full)
//   in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7 - instruction fields
//   in_imm     - sign-extended immediate (byte offset for B/J)
//   out_valid  - out_inst holds an encoded word
//   out_ready  - consumer takes out_inst
//   out_inst   - encoded instruction word (0 while out_valid is low)
//   out_count  - number of words delivered, wraps
//   err        - one-cycle pulse for each dropped field set
//
// Configuration: define IMM_RANGE_CHECK_EN to also drop field sets whose
// immediate does not fit the format; otherwise immediates are truncated.

module inst_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [6:0]         in_opcode,
  input  logic [4:0]         in_rd,
  input  logic [4:0]         in_rs1,
  input  logic [4:0]         in_rs2,
  input  logic [2:0]         in_funct3,
  input  logic [6:0]         in_funct7,
  input  logic [31:0]        in_imm,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_inst,
  output logic [COUNT_W-1:0] out_count,
  output logic               err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  logic [31:0]   enc_word;
  logic          enc_known;
  logic          imm_ok;
  logic          enc_ok;
  logic          accept;
  logic          push;
  logic          pop;

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [OW-1:0] occ;

  // Format packing; fields a format does not define are simply not placed.
  always_comb begin
    enc_word  = 32'd0;
    enc_known = 1'b1;
    case (in_opcode)
      OP_IMM, OP_LOAD, OP_JALR:
        enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      OP_STORE:
        enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      OP_BRANCH:
        enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
      OP_JAL:
        enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      OP_REG:
        enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      default:
        enc_known = 1'b0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // Immediate must be a true sign extension of the encodable width; B/J
  // offsets must also be even because bit 0 is not stored.
  always_comb begin
    imm_ok = 1'b1;
    case (in_opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_STORE:
        imm_ok = (in_imm[31:11] == {21{in_imm[11]}});
      OP_BRANCH:
        imm_ok = (in_imm[31:12] == {20{in_imm[12]}}) && !in_imm[0];
      OP_JAL:
        imm_ok = (in_imm[31:20] == {12{in_imm[20]}}) && !in_imm[0];
      default:
        imm_ok = 1'b1;
    endcase
  end
`else
  // High immediate bits are intentionally discarded by truncation.
  logic unused_imm_hi;
  assign unused_imm_hi = ^in_imm[31:21];
  assign imm_ok        = 1'b1;
`endif

  assign enc_ok    = enc_known && imm_ok;

  // Power-of-two depth: the occupancy MSB alone marks the full state.
  assign in_ready  = !occ[AW];
  assign out_valid = (occ != '0);
  assign accept    = in_valid && in_ready;
  assign push      = accept && enc_ok;
  assign pop       = out_valid && out_ready;
  assign out_inst  = out_valid ? mem[rd_ptr] : 32'd0;

  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem[wr_ptr] <= enc_word;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occ       <= '0;
      out_count <= '0;
      err       <= 1'b0;
    end else begin
      err <= accept && !enc_ok;
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        out_count <= out_count + COUNT_W'(1);
      end
      case ({push, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// tb/tb_inst_encoder.sv - scoreboard testbench for inst_encoder
`timescale 1ns/1ps
module tb_inst_encoder;

  localparam int DEPTH = 2;
  localparam int CW    = 4;
`ifdef IMM_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [6:0]    in_opcode = '0;
  logic [4:0]    in_rd = '0;
  logic [4:0]    in_rs1 = '0;
  logic [4:0]    in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_inst;
  logic [CW-1:0] out_count;
  logic          err;

  int            checks = 0;
  int            failures = 0;
  logic [31:0]   exp_q[$];
  int            ready_mode = 1;
  bit            mon_en = 1'b0;

  always #5 clk = ~clk;

  inst_encoder #(.FIFO_DEPTH(DEPTH), .COUNT_W(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_count(out_count), .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: builds the word with masks and shifts, range via signed arithmetic.
  function automatic logic [32:0] model(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [2:0] f3, input logic [6:0] f7,
                                        input logic [31:0] imm);
    logic [31:0] w;
    logic [31:0] regs;
    int          s;
    bit          known;
    bit          fits;
    s     = $signed(imm);
    regs  = (32'(rs1) << 15) | (32'(f3) << 12) | 32'(op);
    known = 1'b1;
    fits  = 1'b1;
    w     = 32'd0;
    case (op)
      7'h13, 7'h03, 7'h67: begin
        w    = ((imm & 32'hFFF) << 20) | regs | (32'(rd) << 7);
        fits = (s >= -2048) && (s <= 2047);
      end
      7'h23: begin
        w    = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | regs | ((imm & 32'h1F) << 7);
        fits = (s >= -2048) && (s <= 2047);
      end
      7'h63: begin
        w    = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) |
               (32'(rs2) << 20) | regs | (((imm >> 1) & 32'hF) << 8) |
               (((imm >> 11) & 32'h1) << 7);
        fits = (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
      end
      7'h6F: begin
        w    = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
               (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) |
               (32'(rd) << 7) | 32'(op);
        fits = (s >= -1048576) && (s <= 1048575) && (imm[0] == 1'b0);
      end
      7'h33: begin
        w = (32'(f7) << 25) | (32'(rs2) << 20) | regs | (32'(rd) << 7);
      end
      default: known = 1'b0;
    endcase
    return {known && (fits || !RANGE_CHK), w};
  endfunction

  // out_ready driver
  initial begin
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: err, counter, stall stability and scoreboard pops.
  logic          err_exp = 1'b0;
  logic [CW-1:0] cnt_exp = '0;
  bit            stall_prev = 1'b0;
  logic [31:0]   stall_word = '0;
  logic [32:0]   mon_m;

  always @(negedge clk) begin
    if (mon_en) begin
      chk("err", 32'(err), 32'(err_exp));
      chk("out_count", 32'(out_count), 32'(cnt_exp));
      if (stall_prev) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_inst", out_inst, stall_word);
      end
      if (!reset) begin
        err_exp    = 1'b0;
        cnt_exp    = '0;
        stall_prev = 1'b0;
      end else begin
        mon_m   = model(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
        err_exp = in_valid && in_ready && !mon_m[32];
        if (out_valid && exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", out_inst);
        end else if (out_valid && out_ready) begin
          chk("out_inst", out_inst, exp_q.pop_front());
        end
        if (out_valid && out_ready) cnt_exp = cnt_exp + 1'b1;
        stall_prev = out_valid && !out_ready;
        stall_word = out_inst;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] imm, input bit directed, input logic [31:0] dword,
                      input bit dok);
    logic [32:0] m;
    bit          acc;
    int          waits;
    in_valid  = 1'b1;
    in_opcode = op;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    m         = model(op, rd, rs1, rs2, f3, f7, imm);
    acc       = 1'b0;
    waits     = 0;
    while (!acc && waits < 100) begin
      @(negedge clk);
      acc = in_ready && reset;
      @(posedge clk);
      waits++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end else if (directed ? dok : m[32]) begin
      exp_q.push_back(directed ? dword : m[31:0]);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_idle", 32'(out_valid), 32'd0);
  endtask

  logic [6:0]  ops [9] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h33, 7'h00, 7'h7F};
  logic [31:0] bnd [10] = '{32'h7FF, 32'hFFFFF800, 32'h800, 32'hFFFFF7FF, 32'hFFE,
                            32'hFFFFF000, 32'h1000, 32'h3, 32'hFFFFE, 32'h100000};

  initial begin
    logic [31:0] imm;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b1;
    tick();

    // Directed encodings
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1, 32'h00500093, 1'b1);
    @(negedge clk);
    chk("latency_out_valid", 32'(out_valid), 32'd1);
    tick();
    send(7'h23, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 1'b1, 32'h0020A423, 1'b1);
    send(7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFC, 1'b1, 32'hFE000EE3, 1'b1);
    send(7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 1'b1, 32'h008000EF, 1'b1);
    send(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, 1'b1, 32'h80000093, !RANGE_CHK);
    drain();

    // Backpressure: two fill the FIFO, the third is held
    ready_mode = 0;
    tick();
    send(7'h33, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0, 1'b0, 32'd0, 1'b0);
    chk("bp_ready_after_1", 32'(in_ready), 32'd1);
    send(7'h13, 5'd6, 5'd7, 5'd0, 3'd1, 7'd0, 32'd1, 1'b0, 32'd0, 1'b0);
    chk("bp_ready_after_2", 32'(in_ready), 32'd0);
    fork
      send(7'h03, 5'd8, 5'd9, 5'd0, 3'd2, 7'd0, 32'hFFFFFFF0, 1'b0, 32'd0, 1'b0);
      begin
        repeat (3) @(negedge clk);
        chk("bp_held_ready", 32'(in_ready), 32'd0);
        chk("bp_held_valid", 32'(out_valid), 32'd1);
        ready_mode = 1;
      end
    join
    drain();

    // Unknown opcode
    send(7'h00, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b1, 32'd0, 1'b0);
    @(negedge clk);
    chk("badop_no_output", 32'(out_valid), 32'd0);
    tick();

    // Randomized traffic
    ready_mode = 2;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0:       imm = $urandom;
        1:       imm = 32'($urandom_range(0, 63)) - 32'd32;
        default: imm = bnd[$urandom_range(0, 9)];
      endcase
      send(ops[$urandom_range(0, 8)], 5'($urandom), 5'($urandom), 5'($urandom),
           3'($urandom), 7'($urandom), imm, 1'b0, 32'd0, 1'b0);
      if ($urandom_range(0, 3) == 0) tick();
    end
    drain();

    // Reset with two words buffered; a field set in the reset cycle is discarded
    ready_mode = 0;
    tick();
    send(7'h13, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd7, 1'b0, 32'd0, 1'b0);
    send(7'h13, 5'd4, 5'd5, 5'd0, 3'd0, 7'd0, 32'd9, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    tick();
    reset = 1'b0;
    exp_q.delete();
    in_valid  = 1'b1;
    in_opcode = 7'h00;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_count", 32'(out_count), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    reset = 1'b1;
    ready_mode = 1;
    repeat (4) tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, number of encoded words buffered (power of two, >=2).
REQ-002 SHALL have parameter COUNT_W, default 16, width of the emitted-instruction counter.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset (reset==0 resets at the clk edge).
REQ-005 SHALL have port in_valid  input  1  field set on in_* is valid.
REQ-006 SHALL have port in_ready  output  1  encoder can accept a field set.
REQ-007 SHALL have ports in_opcode/in_rd/in_rs1/in_rs2/in_funct3/in_funct7  input  7/5/5/5/3/7  instruction fields.
REQ-008 SHALL have port in_imm  input  32  sign-extended immediate, byte offset for B/J.
REQ-009 SHALL have port out_valid  output  1  out_inst holds an encoded word.
REQ-010 SHALL have port out_ready  input  1  consumer takes out_inst.
REQ-011 SHALL have port out_inst  output  32  encoded RV32I instruction word.
REQ-012 SHALL have port out_count  output  COUNT_W  number of words delivered.
REQ-013 SHALL have port err  output  1  one-cycle pulse marking a dropped field set.

Function
REQ-014 Input handshake SHALL complete on a clk edge with in_valid==1 and in_ready==1; output handshake on out_valid==1 and out_ready==1.
REQ-015 in_ready SHALL be 1 iff the FIFO is not full; no push while full even when a pop occurs that cycle.
REQ-016 Encoding per opcode: I (0010011, 0000011, 1100111) imm[11:0]->[31:20]; S (0100011) imm[11:5]->[31:25], imm[4:0]->[11:7]; B (1100011) imm[12]->[31], imm[10:5]->[30:25], imm[4:1]->[11:8], imm[11]->[7]; J (1101111) imm[20]->[31], imm[10:1]->[30:21], imm[11]->[20], imm[19:12]->[19:12]; R (0110011) funct7->[31:25].
REQ-017 Register/funct fields SHALL occupy standard positions (rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], opcode [6:0]) only where the format defines them; undefined positions come from immediate or are 0.
REQ-018 An accepted field set with any other opcode SHALL be dropped (not pushed) and err SHALL pulse for exactly the following cycle.
REQ-019 An accepted valid field set SHALL be written into the FIFO at the accepting edge; out_valid SHALL be 1 the next cycle (latency 1) if FIFO was empty.
REQ-020 FIFO SHALL be first-in-first-out; out_inst SHALL hold stable while out_valid==1 and out_ready==0.
REQ-021 Simultaneous push and pop on a non-full, non-empty FIFO SHALL leave occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-022 out_count SHALL increment by 1 per output handshake and wrap from 2^COUNT_W-1 to 0.

Reset
REQ-023 On reset==0 at a clk edge: FIFO emptied, out_valid=0, out_inst=0, out_count=0, err=0, in_ready=1 next cycle.
REQ-024 Reset SHALL override any concurrent handshake; a field set presented in the reset cycle is discarded without err.

Configuration
REQ-025 Macro IMM_RANGE_CHECK_EN SHALL, when defined, make the encoder drop and err-pulse any field set whose in_imm is not a sign-extension of 12 bits (I, S), 13 bits with imm[0]==0 (B), or 21 bits with imm[0]==0 (J).
REQ-026 Without IMM_RANGE_CHECK_EN, out-of-range immediates SHALL be silently truncated to the encoded bits and err SHALL fire only for unknown opcodes.

Verification
REQ-027 ADDI rd=1 rs1=0 f3=0 imm=5, out_ready=1 -> out_inst=0x00500093 one cycle later, out_count=1.
REQ-028 SW rs1=1 rs2=2 f3=010 imm=8 -> 0x0020A423; BEQ rs1=rs2=0 imm=-4 -> 0xFE000EE3; JAL rd=1 imm=8 -> 0x008000EF, in order.
REQ-029 ADDI rd=1 imm=0x800: with IMM_RANGE_CHECK_EN -> err pulse, no output; without -> out_inst=0x80000093, err=0.
REQ-030 out_ready=0, three back-to-back pushes (FIFO_DEPTH=2) -> in_ready=0 after second push, third held; out_ready=1 -> all three emitted in order.
REQ-031 opcode=0000000 pushed -> err pulse one cycle, out_valid stays 0; reset==0 with 2 words buffered -> out_valid=0, out_count=0 next cycle.
